id_operand_stage: RTL and testbench
===================================

// Module: id_operand_stage
// PURPOSE
//   Parametrised decode-stage front end for the 5-stage CPU.
//   - Holds the IF->ID pipeline register and captures the synchronous inst-SRAM word so the instruction survives multi-cycle ID stalls.
//   - Resolves rs/rt operands by forwarding from NFWD in-flight writers, with fixed priority.
//   - Raises a load-use interlock request when the winning writer is a load whose data is not yet available.
//   - Sits between IF and the opcode decoder / EX bus packer; replaces ad-hoc per-stage forwarding.
// PARAMETERS
//   XLEN  32  operand / write-data width
//   PC_W  32  program-counter width
//   NFWD  3   forwarding sources; index 0 = highest priority (0=EX, 1=MEM, 2=WB)
//   RAW   5   register-address width; register 0 is hard-wired to zero
// PORTS
//   clk          in   1          clock, all state on rising edge
//   rst          in   1          asynchronous, active-low reset
//   stall_if     in   1          stall bus bit for IF (stall[1])
//   stall_id     in   1          stall bus bit for ID (stall[2])
//   flush        in   1          kill ID contents (branch/exception), sync
//   if_valid     in   1          IF presents a fetched PC this cycle
//   if_pc        in   PC_W       PC of the fetched instruction
//   inst_rdata   in   32         inst-SRAM data, valid the cycle after its PC is captured
//   fwd_we       in   NFWD       per-source register write enable
//   fwd_waddr    in   NFWD*RAW   per-source destination, source i at [i*RAW +: RAW]
//   fwd_wdata    in   NFWD*XLEN  per-source write data
//   fwd_is_load  in   NFWD       per-source: result is a load, wdata not yet valid
//   rf_rdata1    in   XLEN       regfile read data for rf_raddr1
//   rf_rdata2    in   XLEN       regfile read data for rf_raddr2
//   rf_raddr1    out  RAW        rs field (id_inst[25:21])
//   rf_raddr2    out  RAW        rt field (id_inst[20:16])
//   id_valid     out  1          ID holds a live instruction
//   id_pc        out  PC_W       PC of the ID instruction
//   id_inst      out  32         instruction word in ID
//   id_rs_val    out  XLEN       resolved rs operand
//   id_rt_val    out  XLEN       resolved rt operand
//   stallreq_ld  out  1          load-use interlock request to the stall controller
// BEHAVIOUR
//   Reset (rst=0, async)
//     - id_valid=0, id_pc=0, hold_vld=0, hold_inst=0.
//     - Hence id_inst=0, stallreq_ld=0.
//   Pipeline register, evaluated in priority order:
//     1. flush: load a bubble.
//     2. stall_if & !stall_id: load a bubble.
//     3. !stall_if: load {if_valid, if_pc}.
//     4. otherwise: hold.
//     - Bubble = id_valid=0, pc=0.
//     - Any load (cases 1-3) clears hold_vld.
//   Instruction hold
//     - On the first held cycle (stall_id=1 & hold_vld=0), capture inst_rdata into hold_inst and set hold_vld=1.
//     - id_inst = hold_vld ? hold_inst : inst_rdata.
//     - id_inst is forced to 0 when id_valid=0.
//     - A stall of any length N>=1 returns the same word on every cycle.
//   Operand forwarding (combinational, zero latency)
//     - For rs and rt independently, scan i=0..NFWD-1.
//     - The first i with fwd_we[i] & waddr_i==addr & addr!=0 wins; its wdata is used.
//     - If no source wins, use rf_rdataX.
//     - addr==0 always yields 0.
//     - Same-cycle write and read to the same register via the WB source is covered by forwarding; no regfile bypass is assumed.
//   Load-use interlock
//     - stallreq_ld = id_valid & (winner(rs).is_load | winner(rt).is_load).
//     - A higher-priority non-load winner masks a lower-priority load.
//     - Both operands are treated as used (conservative).
//   Simultaneous events
//     - flush overrides stall_id.
//     - Reset mid-stall discards hold_inst.
// TESTING
//   - Reset: drive rst=0 with random inputs -> id_valid=0, id_inst=0, stallreq_ld=0.
//   - Hold: PC 0x100 with inst 0x3C011234, then stall_id=1 for 3 cycles while inst_rdata changes -> id_inst=0x3C011234 throughout.
//   - Priority: rs=5 with EX wdata 0xAA and MEM wdata 0xBB -> id_rs_val=0xAA; drop EX we -> 0xBB.
//   - Zero register: rt=0 with EX writing reg0=0xFFFF -> id_rt_val=0.
//   - Load-use: rs=8 with EX is_load -> stallreq_ld=1. MEM load plus EX non-load on reg 8 -> stallreq_ld=0.
//   - Bubble/flush: stall_if=1, stall_id=0 -> id_valid=0 next cycle. flush during stall_id -> id_valid=0.

Source files
------------

// File: rtl/id_operand_stage.sv
// Decode-stage front end: IF->ID pipeline register with stall-safe instruction hold,
// fixed-priority operand forwarding and load-use interlock request.
module id_operand_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32,
  parameter int NFWD = 3,
  parameter int RAW  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_if,
  input  logic                 stall_id,
  input  logic                 flush,
  input  logic                 if_valid,
  input  logic [PC_W-1:0]      if_pc,
  input  logic [31:0]          inst_rdata,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD*RAW-1:0]  fwd_waddr,
  input  logic [NFWD*XLEN-1:0] fwd_wdata,
  input  logic [NFWD-1:0]      fwd_is_load,
  input  logic [XLEN-1:0]      rf_rdata1,
  input  logic [XLEN-1:0]      rf_rdata2,
  output logic [RAW-1:0]       rf_raddr1,
  output logic [RAW-1:0]       rf_raddr2,
  output logic                 id_valid,
  output logic [PC_W-1:0]      id_pc,
  output logic [31:0]          id_inst,
  output logic [XLEN-1:0]      id_rs_val,
  output logic [XLEN-1:0]      id_rt_val,
  output logic                 stallreq_ld
);

  logic            id_valid_q, id_valid_d;
  logic [PC_W-1:0] id_pc_q, id_pc_d;
  logic            hold_vld_q, hold_vld_d;
  logic [31:0]     hold_inst_q, hold_inst_d;
  logic            load;

  // The SRAM word is only valid for one cycle, so it is latched on the first stalled cycle.
  always_comb begin
    id_valid_d  = id_valid_q;
    id_pc_d     = id_pc_q;
    hold_vld_d  = hold_vld_q;
    hold_inst_d = hold_inst_q;
    load        = 1'b1;
    if (flush || (stall_if && !stall_id)) begin
      id_valid_d = 1'b0;
      id_pc_d    = '0;
    end else if (!stall_if) begin
      id_valid_d = if_valid;
      id_pc_d    = if_pc;
    end else begin
      load = 1'b0;
    end
    if (load) begin
      hold_vld_d = 1'b0;
    end else if (stall_id && !hold_vld_q) begin
      hold_vld_d  = 1'b1;
      hold_inst_d = inst_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid_q  <= 1'b0;
      id_pc_q     <= '0;
      hold_vld_q  <= 1'b0;
      hold_inst_q <= '0;
    end else begin
      id_valid_q  <= id_valid_d;
      id_pc_q     <= id_pc_d;
      hold_vld_q  <= hold_vld_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign id_inst   = id_valid_q ? (hold_vld_q ? hold_inst_q : inst_rdata) : 32'h0;
  assign rf_raddr1 = id_inst[21 +: RAW];
  assign rf_raddr2 = id_inst[16 +: RAW];

  logic rs_ld, rt_ld;

  // Scan from lowest priority upward so the lowest-index match overwrites the rest.
  always_comb begin
    id_rs_val = rf_rdata1;
    id_rt_val = rf_rdata2;
    rs_ld     = 1'b0;
    rt_ld     = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_we[i] && (fwd_waddr[i*RAW +: RAW] == rf_raddr1)) begin
        id_rs_val = fwd_wdata[i*XLEN +: XLEN];
        rs_ld     = fwd_is_load[i];
      end
      if (fwd_we[i] && (fwd_waddr[i*RAW +: RAW] == rf_raddr2)) begin
        id_rt_val = fwd_wdata[i*XLEN +: XLEN];
        rt_ld     = fwd_is_load[i];
      end
    end
    if (rf_raddr1 == '0) begin
      id_rs_val = '0;
      rs_ld     = 1'b0;
    end
    if (rf_raddr2 == '0) begin
      id_rt_val = '0;
      rt_ld     = 1'b0;
    end
  end

  assign stallreq_ld = id_valid_q & (rs_ld | rt_ld);

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios plus randomized
// traffic against a behavioural model of the ID register and forwarding rules.
module tb_id_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_if, stall_id, flush, if_valid;
  logic [31:0] if_pc, inst_rdata;
  logic [2:0]  f_we, f_ld;
  logic [4:0]  f_addr [3];
  logic [31:0] f_data [3];
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [14:0] fwd_waddr;
  logic [95:0] fwd_wdata;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic        id_valid, stallreq_ld;
  logic [31:0] id_pc, id_inst, id_rs_val, id_rt_val;

  assign fwd_waddr = {f_addr[2], f_addr[1], f_addr[0]};
  assign fwd_wdata = {f_data[2], f_data[1], f_data[0]};

  id_operand_stage #(.XLEN(32), .PC_W(32), .NFWD(3), .RAW(5)) dut (
    .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .inst_rdata(inst_rdata),
    .fwd_we(f_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_is_load(f_ld),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .stallreq_ld(stallreq_ld)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: what ID holds, and the instruction word frozen during a stall.
  bit          m_valid;
  logic [31:0] m_pc;
  bit          m_frozen;
  logic [31:0] m_word;

  function automatic void ref_fwd(input logic [4:0] a, input logic [31:0] rf,
                                  output logic [31:0] v, output bit ld);
    v  = rf;
    ld = 1'b0;
    if (a == 5'd0) begin
      v = 32'h0;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (f_we[i] && f_addr[i] == a) begin
        v  = f_data[i];
        ld = f_ld[i];
        return;
      end
    end
  endfunction

  function automatic logic [31:0] exp_inst();
    if (!m_valid) return 32'h0;
    return m_frozen ? m_word : inst_rdata;
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_pc     = 32'h0;
    m_frozen = 1'b0;
    m_word   = 32'h0;
  endtask

  // Advance one clock, updating the model from the inputs present before the edge.
  task automatic tick();
    bit          nv, nfz, took;
    logic [31:0] npc, nw;
    nv = m_valid; npc = m_pc; nfz = m_frozen; nw = m_word; took = 1'b1;
    if (flush)                      begin nv = 1'b0; npc = 32'h0; end
    else if (stall_if && !stall_id) begin nv = 1'b0; npc = 32'h0; end
    else if (!stall_if)             begin nv = if_valid; npc = if_pc; end
    else took = 1'b0;
    if (took) nfz = 1'b0;
    else if (stall_id && !m_frozen) begin nfz = 1'b1; nw = inst_rdata; end
    @(posedge clk); #1;
    m_valid = nv; m_pc = npc; m_frozen = nfz; m_word = nw;
  endtask

  task automatic clear_fwd();
    f_we = 3'b000; f_ld = 3'b000;
    for (int i = 0; i < 3; i++) begin f_addr[i] = 5'd0; f_data[i] = 32'h0; end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    stall_if = 1'($urandom); stall_id = 1'($urandom); flush = 1'($urandom);
    if_valid = 1'b1; if_pc = $urandom; inst_rdata = $urandom;
    f_we = 3'b111; f_ld = 3'b111;
    for (int i = 0; i < 3; i++) begin f_addr[i] = 5'($urandom); f_data[i] = $urandom; end
    rf_rdata1 = $urandom; rf_rdata2 = $urandom;
    repeat (2) @(posedge clk);
    #2;
    model_reset();
    n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", id_valid); end
    n_tests++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", id_pc); end
    n_tests++; if (id_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst got %h want 0", id_inst); end
    n_tests++; if (stallreq_ld !== 1'b0) begin n_fail++; $display("FAIL reset_stallreq got %b want 0", stallreq_ld); end
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; stall_if = 1'b1; stall_id = 1'b1;
    clear_fwd();
    tick();
  endtask

  task automatic test_hold();
    flush = 1'b0; stall_if = 1'b0; stall_id = 1'b0; if_valid = 1'b1; if_pc = 32'h100;
    tick();
    inst_rdata = 32'h3C011234; stall_if = 1'b1; stall_id = 1'b1; if_pc = $urandom;
    #1;
    n_tests++; if (id_pc !== 32'h100) begin n_fail++; $display("FAIL hold_pc got %h want 00000100", id_pc); end
    n_tests++; if (id_inst !== 32'h3C011234) begin n_fail++; $display("FAIL hold_first got %h want 3c011234", id_inst); end
    for (int k = 0; k < 3; k++) begin
      tick();
      inst_rdata = $urandom;
      #1;
      n_tests++;
      if (id_inst !== 32'h3C011234 || id_valid !== 1'b1) begin
        n_fail++; $display("FAIL hold_cycle%0d got %h/%b want 3c011234/1", k, id_inst, id_valid);
      end
    end
  endtask

  task automatic test_priority();
    flush = 1'b0; stall_if = 1'b0; stall_id = 1'b0; if_valid = 1'b1; if_pc = 32'h200;
    clear_fwd();
    tick();
    inst_rdata = {6'h0, 5'd5, 5'd9, 16'h0};
    f_we = 3'b011; f_addr[0] = 5'd5; f_data[0] = 32'hAA; f_addr[1] = 5'd5; f_data[1] = 32'hBB;
    rf_rdata1 = 32'h55;
    #1;
    n_tests++; if (id_rs_val !== 32'hAA) begin n_fail++; $display("FAIL prio_ex got %h want aa", id_rs_val); end
    f_we = 3'b010;
    #1;
    n_tests++; if (id_rs_val !== 32'hBB) begin n_fail++; $display("FAIL prio_mem got %h want bb", id_rs_val); end
    f_we = 3'b000;
    #1;
    n_tests++; if (id_rs_val !== 32'h55) begin n_fail++; $display("FAIL prio_rf got %h want 55", id_rs_val); end
  endtask

  task automatic test_zero_reg();
    inst_rdata = {6'h0, 5'd3, 5'd0, 16'h0};
    f_we = 3'b001; f_addr[0] = 5'd0; f_data[0] = 32'hFFFF; f_ld = 3'b001;
    rf_rdata2 = 32'h1234;
    #1;
    n_tests++; if (id_rt_val !== 32'h0) begin n_fail++; $display("FAIL zero_rt got %h want 0", id_rt_val); end
    n_tests++; if (stallreq_ld !== 1'b0) begin n_fail++; $display("FAIL zero_stallreq got %b want 0", stallreq_ld); end
  endtask

  task automatic test_load_use();
    clear_fwd();
    inst_rdata = {6'h0, 5'd8, 5'd9, 16'h0};
    f_we = 3'b001; f_addr[0] = 5'd8; f_ld = 3'b001;
    #1;
    n_tests++; if (stallreq_ld !== 1'b1) begin n_fail++; $display("FAIL ld_ex got %b want 1", stallreq_ld); end
    f_we = 3'b011; f_addr[1] = 5'd8; f_ld = 3'b010; f_data[0] = 32'hC0DE;
    #1;
    n_tests++; if (stallreq_ld !== 1'b0) begin n_fail++; $display("FAIL ld_masked got %b want 0", stallreq_ld); end
    n_tests++; if (id_rs_val !== 32'hC0DE) begin n_fail++; $display("FAIL ld_masked_val got %h want c0de", id_rs_val); end
    clear_fwd();
  endtask

  task automatic test_bubble_flush();
    flush = 1'b0; stall_if = 1'b0; stall_id = 1'b0; if_valid = 1'b1; if_pc = 32'h300;
    tick();
    stall_if = 1'b1;
    tick();
    n_tests++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_valid got %b want 0", id_valid); end
    stall_if = 1'b0; if_pc = 32'h304;
    tick();
    n_tests++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL reload_valid got %b want 1", id_valid); end
    stall_if = 1'b1; stall_id = 1'b1; flush = 1'b1;
    tick();
    n_tests++;
    if (id_valid !== 1'b0 || id_pc !== 32'h0) begin
      n_fail++; $display("FAIL flush_stall got %b/%h want 0/0", id_valid, id_pc);
    end
    flush = 1'b0; stall_if = 1'b0; stall_id = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] ei, ers, ert;
    bit          lrs, lrt, est;
    for (int n = 0; n < 400; n++) begin
      flush    = ($urandom_range(0, 9) == 0);
      stall_if = ($urandom_range(0, 2) == 0);
      stall_id = stall_if ? 1'($urandom) : ($urandom_range(0, 7) == 0);
      if_valid = ($urandom_range(0, 3) != 0);
      if_pc    = $urandom;
      inst_rdata = {6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      for (int i = 0; i < 3; i++) begin
        f_we[i] = 1'($urandom); f_ld[i] = ($urandom_range(0, 2) == 0);
        f_addr[i] = 5'($urandom_range(0, 7)); f_data[i] = $urandom;
      end
      rf_rdata1 = $urandom; rf_rdata2 = $urandom;
      #1;
      ei = exp_inst();
      ref_fwd(ei[25:21], rf_rdata1, ers, lrs);
      ref_fwd(ei[20:16], rf_rdata2, ert, lrt);
      est = m_valid && (lrs || lrt);
      n_tests++; if (id_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid n=%0d got %b want %b", n, id_valid, m_valid); end
      n_tests++; if (id_pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc n=%0d got %h want %h", n, id_pc, m_pc); end
      n_tests++;
      if (id_inst !== ei || rf_raddr1 !== ei[25:21] || rf_raddr2 !== ei[20:16]) begin
        n_fail++; $display("FAIL rnd_inst n=%0d got %h want %h", n, id_inst, ei);
      end
      n_tests++; if (id_rs_val !== ers) begin n_fail++; $display("FAIL rnd_rs n=%0d got %h want %h", n, id_rs_val, ers); end
      n_tests++; if (id_rt_val !== ert) begin n_fail++; $display("FAIL rnd_rt n=%0d got %h want %h", n, id_rt_val, ert); end
      n_tests++; if (stallreq_ld !== est) begin n_fail++; $display("FAIL rnd_stallreq n=%0d got %b want %b", n, stallreq_ld, est); end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    model_reset();
    clear_fwd();
    test_reset();
    test_hold();
    test_priority();
    test_zero_reg();
    test_load_use();
    test_bubble_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
